eth_tx_framer: RTL and testbench

//  GMII-side byte-stream transmit framer feeding the RGMII DDR output stage (tx_en, tx_data[7:0]).

---
 rtl/eth_tx_framer.sv | 187 ++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// GMII byte-stream transmit framer: preamble, SFD, payload, zero pad, CRC-32 FCS, inter-frame gap.
// Outputs are registered alongside the state, so the state always names the byte currently on the wire.
module eth_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int IFG_LEN      = 12
) (
  input  logic        i_tx_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  input  logic        i_last,
  output logic        o_ready,
  output logic        o_tx_en,
  output logic [7:0]  o_tx_data,
  output logic        o_busy,
  output logic        o_underrun,
  output logic [15:0] o_frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG
  } state_t;

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] IFG_LAST = 16'(IFG_LEN - 1);
  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        last_q, last_d;
  logic        good_q, good_d;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        underrun_q, underrun_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic [10:0] byte_inc;
  logic [31:0] fcs_sel;
  logic [31:0] fcs_shift;
  logic        start;

  // Reflected CRC-32, one byte per call.
  function automatic logic [31:0] crc8(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h000000, b};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  assign o_ready     = (state_q == S_SFD) || ((state_q == S_DATA) && !last_q);
  assign o_busy      = (state_q != S_IDLE);
  assign o_tx_en     = tx_en_q;
  assign o_tx_data   = tx_data_q;
  assign o_underrun  = underrun_q;
  assign o_frame_cnt = frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_cnt_d  = byte_cnt_q;
    crc_d       = crc_q;
    last_d      = last_q;
    good_d      = good_q;
    tx_en_d     = tx_en_q;
    tx_data_d   = tx_data_q;
    underrun_d  = 1'b0;
    frame_cnt_d = frame_cnt_q;
    start       = 1'b0;
    byte_inc    = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 11'd1;
    fcs_sel     = good_q ? ~crc_q : crc_q;
    fcs_shift   = fcs_sel >> {cnt_q[1:0] + 2'd1, 3'b000};

    case (state_q)
      S_IDLE: start = i_valid;
      S_PRE: begin
        if (cnt_q == PRE_LAST) begin
          state_d   = S_SFD;
          tx_data_d = 8'hD5;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_SFD, S_DATA: begin
        if (o_ready) begin
          if (i_valid) begin
            state_d    = S_DATA;
            tx_data_d  = i_data;
            crc_d      = crc8(crc_q, i_data);
            byte_cnt_d = byte_inc;
            last_d     = i_last;
          end else begin
            // Starved source: close with the raw CRC so the receiver discards the frame.
            state_d    = S_FCS;
            underrun_d = 1'b1;
            good_d     = 1'b0;
            cnt_d      = '0;
            tx_data_d  = crc_q[7:0];
          end
        end else if (byte_cnt_q < MIN_CNT) begin
          state_d    = S_PAD;
          tx_data_d  = '0;
          crc_d      = crc8(crc_q, 8'h00);
          byte_cnt_d = byte_inc;
        end else begin
          state_d   = S_FCS;
          cnt_d     = '0;
          tx_data_d = ~crc_q[7:0];
        end
      end
      S_PAD: begin
        if (byte_cnt_q >= MIN_CNT) begin
          state_d   = S_FCS;
          cnt_d     = '0;
          tx_data_d = ~crc_q[7:0];
        end else begin
          crc_d      = crc8(crc_q, 8'h00);
          byte_cnt_d = byte_inc;
        end
      end
      S_FCS: begin
        if (cnt_q[1:0] == 2'd3) begin
          state_d   = S_IFG;
          cnt_d     = '0;
          tx_en_d   = 1'b0;
          tx_data_d = '0;
          if (good_q) frame_cnt_d = frame_cnt_q + 16'd1;
        end else begin
          cnt_d     = cnt_q + 16'd1;
          tx_data_d = fcs_shift[7:0];
        end
      end
      S_IFG: begin
        // The closing gap edge doubles as the first IDLE edge, keeping the gap at exactly IFG_LEN.
        if (cnt_q == IFG_LAST) begin
          state_d = S_IDLE;
          start   = i_valid;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d    = S_PRE;
      tx_en_d    = 1'b1;
      tx_data_d  = 8'h55;
      cnt_d      = '0;
      crc_d      = '1;
      byte_cnt_d = '0;
      last_d     = 1'b0;
      good_d     = 1'b1;
    end
  end

  always_ff @(posedge i_tx_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      byte_cnt_q  <= '0;
      crc_q       <= '1;
      last_q      <= 1'b0;
      good_q      <= 1'b0;
      tx_en_q     <= 1'b0;
      tx_data_q   <= '0;
      underrun_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_q       <= crc_d;
      last_q      <= last_d;
      good_q      <= good_d;
      tx_en_q     <= tx_en_d;
      tx_data_q   <= tx_data_d;
      underrun_q  <= underrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: expected wire bytes and frame lengths are queued at stimulus time
// and compared by per-instance monitors on the falling clock edge.
module tb_eth_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_valid, a_last, a_ready, a_tx_en, a_busy, a_under;
  logic [7:0]  a_data, a_tx_data;
  logic [15:0] a_cnt;
  logic        b_valid, b_last, b_ready, b_tx_en, b_busy, b_under;
  logic [7:0]  b_data, b_tx_data;
  logic [15:0] b_cnt;

  eth_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(60), .IFG_LEN(12)) u_a (
    .i_tx_clk(clk), .i_rst(rst), .i_valid(a_valid), .i_data(a_data), .i_last(a_last),
    .o_ready(a_ready), .o_tx_en(a_tx_en), .o_tx_data(a_tx_data), .o_busy(a_busy),
    .o_underrun(a_under), .o_frame_cnt(a_cnt)
  );

  eth_tx_framer #(.PREAMBLE_LEN(7), .MIN_FRAME(0), .IFG_LEN(12)) u_b (
    .i_tx_clk(clk), .i_rst(rst), .i_valid(b_valid), .i_data(b_data), .i_last(b_last),
    .o_ready(b_ready), .o_tx_en(b_tx_en), .o_tx_data(b_tx_data), .o_busy(b_busy),
    .o_underrun(b_under), .o_frame_cnt(b_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int         len_a[$];
  int         len_b[$];
  logic [7:0] pl[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic push_b(input bit sel, input logic [7:0] v);
    if (sel) exp_b.push_back(v); else exp_a.push_back(v);
  endtask

  task automatic push_expect(input bit sel, input int n, input int min_frame, input bit good);
    logic [31:0] crc;
    logic [31:0] fcs;
    int cnt;
    crc = 32'hFFFFFFFF;
    cnt = n;
    for (int i = 0; i < 7; i++) push_b(sel, 8'h55);
    push_b(sel, 8'hD5);
    for (int i = 0; i < n; i++) begin
      push_b(sel, pl[i]);
      crc = crc_model(crc, pl[i]);
    end
    if (good) begin
      while (cnt < min_frame) begin
        push_b(sel, 8'h00);
        crc = crc_model(crc, 8'h00);
        cnt++;
      end
    end
    fcs = good ? ~crc : crc;
    for (int k = 0; k < 4; k++) begin
      push_b(sel, fcs[7:0]);
      fcs = fcs >> 8;
    end
    if (sel) len_b.push_back(8 + cnt + 4); else len_a.push_back(8 + cnt + 4);
  endtask

  task automatic set_in(input bit sel, input logic v, input logic [7:0] d, input logic l);
    if (sel) begin b_valid = v; b_data = d; b_last = l; end
    else     begin a_valid = v; a_data = d; a_last = l; end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? b_ready : a_ready;
  endfunction

  function automatic logic bsy(input bit sel);
    return sel ? b_busy : a_busy;
  endfunction

  // Offers pl[0..] one byte at a time; returns #1 after the edge that accepted the last offered byte.
  task automatic drive_frame(input bit sel, input int n, input int stop_at);
    int lim;
    lim = (stop_at > 0) ? stop_at : n;
    for (int i = 0; i < lim; i++) begin
      logic acc;
      int t;
      acc = 1'b0;
      t = 0;
      set_in(sel, 1'b1, pl[i], (i == n - 1));
      while (!acc && t < 200) begin
        acc = rdy(sel);
        @(posedge clk); #1;
        t++;
      end
      check("accept", acc, 1);
    end
  endtask

  task automatic wait_idle(input bit sel);
    int t;
    t = 0;
    while (bsy(sel) && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check("idle_wait", bsy(sel), 0);
  endtask

  // Monitor A: wire bytes, frame lengths, o_ready in PRE/SFD/IFG, inter-frame gap.
  int   run_a = 0, idle_a = 0;
  logic prev_a = 1'b0;
  bit   gapchk_a = 1'b0;
  always @(negedge clk) begin
    if (a_tx_en) begin
      if (!prev_a) begin
        if (gapchk_a) begin
          check("a_ifg_gap", idle_a, 12);
          gapchk_a = 1'b0;
        end
        idle_a = 0;
      end
      if (run_a < 8) check("a_ready_pre", a_ready, (run_a == 7));
      if (exp_a.size() == 0) check("a_unexpected_byte", exp_a.size(), 1);
      else check("a_byte", a_tx_data, exp_a.pop_front());
      run_a++;
    end else begin
      if (prev_a) begin
        if (len_a.size() == 0) check("a_len_queue", len_a.size(), 1);
        else check("a_len", run_a, len_a.pop_front());
        run_a = 0;
      end
      idle_a++;
      if (a_busy) check("a_ready_ifg", a_ready, 0);
    end
    prev_a = a_tx_en;
  end

  int   run_b = 0;
  logic prev_b = 1'b0;
  always @(negedge clk) begin
    if (b_tx_en) begin
      if (exp_b.size() == 0) check("b_unexpected_byte", exp_b.size(), 1);
      else check("b_byte", b_tx_data, exp_b.pop_front());
      run_b++;
    end else if (prev_b) begin
      if (len_b.size() == 0) check("b_len_queue", len_b.size(), 1);
      else check("b_len", run_b, len_b.pop_front());
      run_b = 0;
    end
    prev_b = b_tx_en;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_in(0, 1'b0, 8'h00, 1'b0);
    set_in(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_en", a_tx_en, 0);
    check("rst_tx_data", a_tx_data, 0);
    check("rst_ready", a_ready, 0);
    check("rst_busy", a_busy, 0);
    check("rst_underrun", a_under, 0);
    check("rst_frame_cnt", a_cnt, 0);
    check("rst_b_tx_en", b_tx_en, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // MIN_FRAME=0, "123456789": known FCS 26 39 F4 CB.
    for (int i = 0; i < 7; i++) exp_b.push_back(8'h55);
    exp_b.push_back(8'hD5);
    pl.delete();
    for (int i = 0; i < 9; i++) begin
      pl.push_back(8'h31 + 8'(i));
      exp_b.push_back(8'h31 + 8'(i));
    end
    exp_b.push_back(8'h26); exp_b.push_back(8'h39);
    exp_b.push_back(8'hF4); exp_b.push_back(8'hCB);
    len_b.push_back(21);
    drive_frame(1, 9, 0);
    set_in(1, 1'b0, 8'h00, 1'b0);
    wait_idle(1);
    check("b_frame_cnt", b_cnt, 1);

    // One-byte payload, padded to 60.
    pl.delete();
    pl.push_back(8'hAA);
    push_expect(0, 1, 60, 1);
    drive_frame(0, 1, 0);
    set_in(0, 1'b0, 8'h00, 1'b0);
    wait_idle(0);
    check("frame_cnt_pad", a_cnt, 1);

    // 100-byte payload, no padding.
    pl.delete();
    for (int i = 0; i < 100; i++) pl.push_back(8'(i * 7 + 3));
    push_expect(0, 100, 60, 1);
    drive_frame(0, 100, 0);
    set_in(0, 1'b0, 8'h00, 1'b0);
    wait_idle(0);
    check("frame_cnt_long", a_cnt, 2);

    // Underrun after the 5th byte.
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'($urandom));
    push_expect(0, 5, 60, 0);
    drive_frame(0, 20, 5);
    set_in(0, 1'b0, 8'h00, 1'b0);
    check("underrun_before", a_under, 0);
    @(posedge clk); #1;
    check("underrun_pulse", a_under, 1);
    @(posedge clk); #1;
    check("underrun_after", a_under, 0);
    wait_idle(0);
    check("frame_cnt_underrun", a_cnt, 2);

    // Two 64-byte frames with i_valid held high throughout.
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'($urandom));
    push_expect(0, 64, 60, 1);
    drive_frame(0, 64, 0);
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'($urandom));
    push_expect(0, 64, 60, 1);
    gapchk_a = 1'b1;
    drive_frame(0, 64, 0);
    set_in(0, 1'b0, 8'h00, 1'b0);
    wait_idle(0);
    check("frame_cnt_b2b", a_cnt, 4);
    check("gap_seen", gapchk_a, 0);

    // Reset while the 20th payload byte is on the wire.
    pl.delete();
    for (int i = 0; i < 40; i++) pl.push_back(8'($urandom));
    push_expect(0, 40, 60, 1);
    drive_frame(0, 40, 20);
    rst = 1'b1;
    set_in(0, 1'b0, 8'h00, 1'b0);
    exp_a.delete();
    len_a.delete();
    len_a.push_back(27);
    #1;
    check("async_rst_tx_en", a_tx_en, 0);
    check("async_rst_busy", a_busy, 0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_tx_data", a_tx_data, 0);
    check("mid_rst_ready", a_ready, 0);
    check("mid_rst_underrun", a_under, 0);
    check("mid_rst_frame_cnt", a_cnt, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
    push_expect(0, 10, 60, 1);
    drive_frame(0, 10, 0);
    set_in(0, 1'b0, 8'h00, 1'b0);
    wait_idle(0);
    check("frame_cnt_after_rst", a_cnt, 1);

    repeat (5) @(posedge clk);
    #1;
    check("a_leftover_bytes", exp_a.size(), 0);
    check("a_leftover_lens", len_a.size(), 0);
    check("b_leftover_bytes", exp_b.size(), 0);
    check("b_leftover_lens", len_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
